// File: rtl/izh_param_loader.sv
// Serial parameter transmitter for the Izhikevich neuron load_mode/serial_data port.
// Define IZH_LOADER_PARITY_EN to append an even-parity bit to each frame.
module izh_param_loader #(
   parameter int NUM_PARAMS  = 4,
   parameter int PARAM_WIDTH = 8,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              enable,
   input  logic                              start,
   input  logic [NUM_PARAMS*PARAM_WIDTH-1:0] param_word,
   input  logic                              params_ready,
   output logic                              load_mode,
   output logic                              serial_data,
   output logic                              busy,
   output logic                              done,
   output logic                              error
);

   localparam int TOTAL = NUM_PARAMS * PARAM_WIDTH;
`ifdef IZH_LOADER_PARITY_EN
   localparam int NBITS = TOTAL + 1;
`else
   localparam int NBITS = TOTAL;
`endif
   localparam int BW = $clog2(TOTAL + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [NBITS-1:0] r_shreg;
   logic [NBITS-1:0] w_shreg_nxt;
   logic [NBITS-1:0] w_latch;
   logic [BW-1:0]    r_bit_cnt;
   logic [BW-1:0]    w_bit_nxt;
   logic [TW-1:0]    r_tmo_cnt;
   logic [TW-1:0]    w_tmo_nxt;
   logic             r_err;
   logic             w_err_nxt;
   logic             w_last_bit;
   logic             w_tmo_last;
   logic             w_load_nxt;
   logic             w_sdata_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;
   logic             r_load;
   logic             r_sdata;
   logic             r_busy;
   logic             r_done;

`ifdef IZH_LOADER_PARITY_EN
   // Parity rides at the LSB so it leaves the shifter right after the data.
   assign w_latch = {param_word, ^param_word};
`else
   assign w_latch = param_word;
`endif

   assign w_last_bit = (r_bit_cnt == BW'(NBITS - 1));
   assign w_tmo_last = (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else if (enable) begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_shreg_nxt = r_shreg;
      w_bit_nxt   = r_bit_cnt;
      w_tmo_nxt   = r_tmo_cnt;
      w_err_nxt   = r_err;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_SHIFT;
               w_shreg_nxt = w_latch;
               w_bit_nxt   = '0;
               w_tmo_nxt   = '0;
               w_err_nxt   = 1'b0;
            end
         end
         S_SHIFT: begin
            w_shreg_nxt = r_shreg << 1;
            if (w_last_bit) begin
               w_state_nxt = S_WAIT;
               w_tmo_nxt   = '0;
            end else begin
               w_bit_nxt = r_bit_cnt + BW'(1);
            end
         end
         S_WAIT: begin
            if (params_ready) begin
               w_state_nxt = S_DONE;
               w_err_nxt   = 1'b0;
            end else if (w_tmo_last) begin
               w_state_nxt = S_DONE;
               w_err_nxt   = 1'b1;
            end else begin
               w_tmo_nxt = r_tmo_cnt + TW'(1);
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded from next-state values so they leave on flops.
   always_comb begin
      w_load_nxt  = (w_state_nxt == S_SHIFT);
      w_sdata_nxt = w_load_nxt & w_shreg_nxt[NBITS-1];
      w_busy_nxt  = (w_state_nxt != S_IDLE);
      w_done_nxt  = (w_state_nxt == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shreg   <= '0;
         r_bit_cnt <= '0;
         r_tmo_cnt <= '0;
         r_err     <= 1'b0;
      end else if (enable) begin
         r_shreg   <= w_shreg_nxt;
         r_bit_cnt <= w_bit_nxt;
         r_tmo_cnt <= w_tmo_nxt;
         r_err     <= w_err_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_load  <= 1'b0;
         r_sdata <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (enable) begin
         r_load  <= w_load_nxt;
         r_sdata <= w_sdata_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign load_mode   = r_load;
   assign serial_data = r_sdata;
   assign busy        = r_busy;
   assign done        = r_done;
   assign error       = r_err;

endmodule

// File: tb/tb_izh_param_loader.sv
// Directed bench for izh_param_loader: framing, timeout, stall, reject, reset.
// Tracks IZH_LOADER_PARITY_EN to expect the optional parity bit.
module tb_izh_param_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b1;
   logic        start = 1'b0;
   logic [31:0] param_word = '0;
   logic        params_ready = 1'b0;
   logic        load_mode;
   logic        serial_data;
   logic        busy;
   logic        done;
   logic        error;

`ifdef IZH_LOADER_PARITY_EN
   localparam int NB = 33;
   localparam logic [63:0] EXP_NOM = 64'h0000_0000_0433_8210;
`else
   localparam int NB = 32;
   localparam logic [63:0] EXP_NOM = 64'h0000_0000_0219_C108;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [63:0] bits;
   int          nb;
   int          hi;
   int          w;
   logic        hok;
   logic        ea;
   logic        saw_done;

   izh_param_loader dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .start        (start),
      .param_word   (param_word),
      .params_ready (params_ready),
      .load_mode    (load_mode),
      .serial_data  (serial_data),
      .busy         (busy),
      .done         (done),
      .error        (error)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] exp_bits(input logic [31:0] wd);
`ifdef IZH_LOADER_PARITY_EN
      return {31'd0, wd, ^wd};
`else
      return {32'd0, wd};
`endif
   endfunction

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [31:0] wd, input bit stall, input bit inj,
                        output logic [63:0] b, output int n, output int h,
                        output logic hold_ok, output logic err_acc);
      param_word = wd;
      start = 1'b1;
      tick();
      start = 1'b0;
      err_acc = error;
      b = '0;
      n = 0;
      h = 0;
      hold_ok = 1'b1;
      for (int g = 0; g < 300 && load_mode; g++) begin
         b = {b[62:0], serial_data};
         n++;
         h++;
         if (stall && n == 11) begin
            enable = 1'b0;
            for (int k = 0; k < 5; k++) begin
               tick();
               h++;
               if (load_mode !== 1'b1 || serial_data !== b[0]) hold_ok = 1'b0;
            end
            enable = 1'b1;
         end
         if (inj && n == 5) begin
            param_word = 32'hFFFF_FFFF;
            start = 1'b1;
         end
         tick();
         start = 1'b0;
      end
   endtask

   initial begin
      #100us;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // reset with start asserted
      rst_n = 1'b0;
      start = 1'b1;
      param_word = 32'hDEAD_BEEF;
      repeat (3) tick();
      check("rst_outs", 64'({load_mode, serial_data, busy, done, error}), 64'd0);
      start = 1'b0;
      rst_n = 1'b1;
      repeat (3) tick();
      check("post_rst", 64'({load_mode, serial_data, busy, done, error}), 64'd0);

      // nominal frame, ready 3 cycles after load_mode falls
      frame(32'h0219_C108, 1'b0, 1'b0, bits, nb, hi, hok, ea);
      check("nom_len", 64'(hi), 64'(NB));
      check("nom_bits", bits, EXP_NOM);
      check("nom_busy_wait", 64'({busy, load_mode, serial_data}), 64'b100);
      repeat (3) tick();
      check("nom_pre_done", 64'(done), 64'd0);
      params_ready = 1'b1;
      tick();
      params_ready = 1'b0;
      check("nom_done", 64'({done, error, busy}), 64'b101);
      start = 1'b1;
      param_word = 32'h1234_5678;
      tick();
      start = 1'b0;
      check("start_in_done", 64'({busy, load_mode, done}), 64'd0);
      tick();
      check("still_idle", 64'({busy, load_mode}), 64'd0);

      // timeout
      frame(32'hA5A5_0F0F, 1'b0, 1'b0, bits, nb, hi, hok, ea);
      check("tmo_bits", bits, exp_bits(32'hA5A5_0F0F));
      w = 0;
      while (!done && w < 200) begin
         tick();
         w++;
      end
      check("tmo_cycles", 64'(w), 64'd64);
      check("tmo_err", 64'(error), 64'd1);
      tick();
      check("tmo_err_idle", 64'({error, busy, done}), 64'b100);
      repeat (4) tick();
      check("tmo_err_sticky", 64'(error), 64'd1);

      // busy rejection with early ready; accepting start clears error
      params_ready = 1'b1;
      frame(32'h3C5A_9601, 1'b0, 1'b1, bits, nb, hi, hok, ea);
      check("err_clr_acc", 64'(ea), 64'd0);
      check("rej_len", 64'(nb), 64'(NB));
      check("rej_bits", bits, exp_bits(32'h3C5A_9601));
      check("early_no_done", 64'(done), 64'd0);
      tick();
      params_ready = 1'b0;
      check("early_done", 64'({done, error}), 64'b10);
      tick();

      // enable stall mid-frame
      frame(32'h0219_C108, 1'b1, 1'b0, bits, nb, hi, hok, ea);
      check("stall_len", 64'(hi), 64'(NB + 5));
      check("stall_bits", bits, EXP_NOM);
      check("stall_hold", 64'(hok), 64'd1);
      params_ready = 1'b1;
      tick();
      params_ready = 1'b0;
      check("stall_done", 64'(done), 64'd1);
      tick();

      // LSB set: last framed bit is 1 with or without parity
      frame(32'h0000_0001, 1'b0, 1'b0, bits, nb, hi, hok, ea);
      check("lsb_len", 64'(nb), 64'(NB));
      check("lsb_last", 64'(bits[0]), 64'd1);
      check("lsb_bits", bits, exp_bits(32'h0000_0001));
      params_ready = 1'b1;
      tick();
      params_ready = 1'b0;
      tick();

      // asynchronous reset at bit 20
      param_word = 32'h0219_C108;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (20) tick();
      check("mid_load_hi", 64'(load_mode), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_async", 64'({load_mode, busy, done, serial_data}), 64'd0);
      saw_done = 1'b0;
      repeat (3) begin
         tick();
         if (done) saw_done = 1'b1;
      end
      rst_n = 1'b1;
      repeat (5) begin
         tick();
         if (done || busy) saw_done = 1'b1;
      end
      check("mid_rst_no_done", 64'(saw_done), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
